// File: rtl/nvme_pkg.sv
// nvme_pkg: shared constants, RQ descriptor field layout and doorbell FSM states
// used by the NVMe doorbell writer and its descriptor packer.
package nvme_pkg;

  localparam logic [63:0] NVME_DB_BASE_OFFSET = 64'h1000;
  localparam logic [3:0]  RQ_REQ_MEMWR        = 4'b0001;

  localparam int RQ_DESC_W         = 128;
  localparam int RQ_DESC_ADDR_LSB  = 2;
  localparam int RQ_DESC_ADDR_MSB  = 63;
  localparam int RQ_DESC_DWCNT_LSB = 64;
  localparam int RQ_DESC_DWCNT_W   = 11;
  localparam int RQ_DESC_REQ_LSB   = 75;
  localparam int RQ_DESC_REQ_W     = 4;
  localparam int RQ_DESC_TAG_LSB   = 96;
  localparam int RQ_DESC_TAG_W     = 8;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_HDR,
    DB_DATA,
    DB_DONE
  } db_state_e;

endpackage

// File: rtl/nvme_rq_mwr_desc.sv
// nvme_rq_mwr_desc: combinational packer for the 128-bit RQ Memory Write descriptor
// (address, dword count, request type, tag; all other fields zero).
module nvme_rq_mwr_desc
  import nvme_pkg::*;
(
  input  logic [63:0]                addr_i,
  input  logic [RQ_DESC_DWCNT_W-1:0] dw_cnt_i,
  input  logic [RQ_DESC_TAG_W-1:0]   tag_i,
  output logic [RQ_DESC_W-1:0]       desc_o
);

  // The address field is DW-aligned, so the two byte-offset bits are dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr_i[RQ_DESC_ADDR_LSB-1:0];

  always_comb begin
    // NOTE: default the whole output first so every path assigns every bit and no latch is inferred.
    desc_o = '0;
    desc_o[RQ_DESC_ADDR_MSB:RQ_DESC_ADDR_LSB]      = addr_i[RQ_DESC_ADDR_MSB:RQ_DESC_ADDR_LSB];
    desc_o[RQ_DESC_DWCNT_LSB +: RQ_DESC_DWCNT_W]   = dw_cnt_i;
    desc_o[RQ_DESC_REQ_LSB +: RQ_DESC_REQ_W]       = RQ_REQ_MEMWR;
    desc_o[RQ_DESC_TAG_LSB +: RQ_DESC_TAG_W]       = tag_i;
  end

endmodule

// File: rtl/nvme_doorbell_writer.sv
// nvme_doorbell_writer: latches SQ-tail / CQ-head doorbell requests and writes each as a
// 1-DW PCIe MemWr on the RQ stream. Optional counters with NVME_DB_WRITER_STATS_EN.
module nvme_doorbell_writer
  import nvme_pkg::*;
#(
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 62,
  parameter logic [63:0] BAR0_BASE           = 64'h0,
  parameter int          DSTRD               = 0,
  parameter int          QID                 = 0
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           user_lnk_up,
  input  logic                           write_sqtdbl,
  input  logic [63:0]                    sqt_addr,
  input  logic                           write_cqhdbl,
  input  logic [63:0]                    cqh_addr,
  output logic                           write_sqtdbl_done,
  output logic                           write_cqhdbl_done,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                           s_axis_rq_tvalid,
`ifdef NVME_DB_WRITER_STATS_EN
  output logic [31:0]                    sq_db_count,
  output logic [31:0]                    cq_db_count,
  output logic [15:0]                    coalesce_count,
`endif
  input  logic                           s_axis_rq_tready
);

  localparam logic [63:0] DB_STRIDE  = 64'd4 << DSTRD;
  localparam logic [63:0] SQ_DB_ADDR = BAR0_BASE + NVME_DB_BASE_OFFSET
                                       + (64'(QID) * 64'd2) * DB_STRIDE;
  localparam logic [63:0] CQ_DB_ADDR = SQ_DB_ADDR + DB_STRIDE;

  db_state_e                      state_q;
  logic                           sq_pend_q, sq_pend_d, cq_pend_q, cq_pend_d;
  logic [15:0]                    sq_val_q, sq_val_d, cq_val_q, cq_val_d;
  logic [15:0]                    val_q;
  logic                           served_cq_q;
  logic [7:0]                     tag_q;
  logic                           sel_sq, sel_cq;
  logic [RQ_DESC_W-1:0]           hdr_desc;
  logic [C_DATA_WIDTH-1:0]        tdata_q;
  logic [KEEP_WIDTH-1:0]          tkeep_q;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_q;
  logic                           tlast_q, tvalid_q, sq_done_q, cq_done_q;

  // Only the low 16 bits of the doorbell values are meaningful.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{sqt_addr[63:16], cqh_addr[63:16]};

  // A new pulse wins over the clear issued by the IDLE selection in the same cycle,
  // so a request arriving while its own TLP is frozen is served afterwards.
  always_comb begin
    sel_cq    = user_lnk_up && (state_q == DB_IDLE) && cq_pend_q;
    sel_sq    = user_lnk_up && (state_q == DB_IDLE) && !cq_pend_q && sq_pend_q;
    sq_pend_d = sq_pend_q && !sel_sq;
    cq_pend_d = cq_pend_q && !sel_cq;
    sq_val_d  = sq_val_q;
    cq_val_d  = cq_val_q;
    if (write_sqtdbl) begin
      sq_pend_d = 1'b1;
      sq_val_d  = sqt_addr[15:0];
    end
    if (write_cqhdbl) begin
      cq_pend_d = 1'b1;
      cq_val_d  = cqh_addr[15:0];
    end
    if (!user_lnk_up) begin
      sq_pend_d = 1'b0;
      cq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      sq_pend_q <= 1'b0;
      cq_pend_q <= 1'b0;
      sq_val_q  <= '0;
      cq_val_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      sq_pend_q <= sq_pend_d;
      cq_pend_q <= cq_pend_d;
      sq_val_q  <= sq_val_d;
      cq_val_q  <= cq_val_d;
    end
  end

  nvme_rq_mwr_desc u_desc (
    .addr_i   (sel_cq ? CQ_DB_ADDR : SQ_DB_ADDR),
    .dw_cnt_i (RQ_DESC_DWCNT_W'(1)),
    .tag_i    (tag_q),
    .desc_o   (hdr_desc)
  );

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= DB_IDLE;
      val_q       <= '0;
      served_cq_q <= 1'b0;
      tag_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      sq_done_q   <= 1'b0;
      cq_done_q   <= 1'b0;
    end else if (!user_lnk_up) begin
      state_q   <= DB_IDLE;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tuser_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      sq_done_q <= 1'b0;
      cq_done_q <= 1'b0;
    end else begin
      sq_done_q <= 1'b0;
      cq_done_q <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (sel_cq || sel_sq) begin
            served_cq_q <= sel_cq;
            val_q       <= sel_cq ? cq_val_q : sq_val_q;
            tdata_q     <= C_DATA_WIDTH'(hdr_desc);
            tkeep_q     <= KEEP_WIDTH'(4'hF);
            tuser_q     <= AXI4_RQ_TUSER_WIDTH'(4'hF);
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b1;
            state_q     <= DB_HDR;
          end
        end
        DB_HDR: begin
          if (s_axis_rq_tready) begin
            tdata_q <= C_DATA_WIDTH'(val_q);
            tkeep_q <= KEEP_WIDTH'(1'b1);
            tuser_q <= '0;
            tlast_q <= 1'b1;
            state_q <= DB_DATA;
          end
        end
        DB_DATA: begin
          if (s_axis_rq_tready) begin
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            tag_q     <= tag_q + 8'd1;
            sq_done_q <= !served_cq_q;
            cq_done_q <= served_cq_q;
            state_q   <= DB_DONE;
          end
        end
        default: state_q <= DB_IDLE;
      endcase
    end
  end

  assign s_axis_rq_tdata   = tdata_q;
  assign s_axis_rq_tkeep   = tkeep_q;
  assign s_axis_rq_tuser   = tuser_q;
  assign s_axis_rq_tlast   = tlast_q;
  assign s_axis_rq_tvalid  = tvalid_q;
  assign write_sqtdbl_done = sq_done_q;
  assign write_cqhdbl_done = cq_done_q;

`ifdef NVME_DB_WRITER_STATS_EN
  // A pulse only coalesces when its flag is still set and not being taken this cycle.
  logic        sq_coalesce, cq_coalesce;
  logic [16:0] coal_sum;
  logic [31:0] sq_cnt_q, cq_cnt_q;
  logic [15:0] coal_cnt_q;

  assign sq_coalesce = user_lnk_up && write_sqtdbl && sq_pend_q && !sel_sq;
  assign cq_coalesce = user_lnk_up && write_cqhdbl && cq_pend_q && !sel_cq;
  assign coal_sum    = 17'(coal_cnt_q) + 17'(sq_coalesce) + 17'(cq_coalesce);

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      sq_cnt_q   <= '0;
      cq_cnt_q   <= '0;
      coal_cnt_q <= '0;
    end else begin
      if (sq_done_q) sq_cnt_q <= sq_cnt_q + 32'd1;
      if (cq_done_q) cq_cnt_q <= cq_cnt_q + 32'd1;
      coal_cnt_q <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
    end
  end

  assign sq_db_count    = sq_cnt_q;
  assign cq_db_count    = cq_cnt_q;
  assign coalesce_count = coal_cnt_q;
`endif

endmodule

// File: tb/tb_nvme_doorbell_writer.sv
// tb_nvme_doorbell_writer: directed bench for nvme_doorbell_writer; a second instance with
// DSTRD=1, QID=1 shares the stimulus for the doorbell stride/offset case.
module tb_nvme_doorbell_writer;

  localparam logic [63:0] BAR = 64'h0000_0000_9100_0000;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic [61:0]  user;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, lnk_up, wsq, wcq, tready;
  logic [63:0]  sqa, cqa;
  logic         sq_done_a, cq_done_a, tlast_a, tvalid_a;
  logic [127:0] tdata_a;
  logic [3:0]   tkeep_a;
  logic [61:0]  tuser_a;
  logic         sq_done_b, cq_done_b, tlast_b, tvalid_b;
  logic [127:0] tdata_b;
  logic [3:0]   tkeep_b;
  logic [61:0]  tuser_b;
`ifdef NVME_DB_WRITER_STATS_EN
  logic [31:0]  sq_cnt_a, cq_cnt_a, sq_cnt_b, cq_cnt_b;
  logic [15:0]  coal_a, coal_b;
`endif

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_tag;

  nvme_doorbell_writer #(.BAR0_BASE(BAR)) dut (
    .user_clk          (clk),
    .user_reset_n      (rst_n),
    .user_lnk_up       (lnk_up),
    .write_sqtdbl      (wsq),
    .sqt_addr          (sqa),
    .write_cqhdbl      (wcq),
    .cqh_addr          (cqa),
    .write_sqtdbl_done (sq_done_a),
    .write_cqhdbl_done (cq_done_a),
    .s_axis_rq_tdata   (tdata_a),
    .s_axis_rq_tkeep   (tkeep_a),
    .s_axis_rq_tlast   (tlast_a),
    .s_axis_rq_tuser   (tuser_a),
    .s_axis_rq_tvalid  (tvalid_a),
`ifdef NVME_DB_WRITER_STATS_EN
    .sq_db_count       (sq_cnt_a),
    .cq_db_count       (cq_cnt_a),
    .coalesce_count    (coal_a),
`endif
    .s_axis_rq_tready  (tready)
  );

  nvme_doorbell_writer #(.BAR0_BASE(BAR), .DSTRD(1), .QID(1)) dut_b (
    .user_clk          (clk),
    .user_reset_n      (rst_n),
    .user_lnk_up       (lnk_up),
    .write_sqtdbl      (wsq),
    .sqt_addr          (sqa),
    .write_cqhdbl      (wcq),
    .cqh_addr          (cqa),
    .write_sqtdbl_done (sq_done_b),
    .write_cqhdbl_done (cq_done_b),
    .s_axis_rq_tdata   (tdata_b),
    .s_axis_rq_tkeep   (tkeep_b),
    .s_axis_rq_tlast   (tlast_b),
    .s_axis_rq_tuser   (tuser_b),
    .s_axis_rq_tvalid  (tvalid_b),
`ifdef NVME_DB_WRITER_STATS_EN
    .sq_db_count       (sq_cnt_b),
    .cq_db_count       (cq_cnt_b),
    .coalesce_count    (coal_b),
`endif
    .s_axis_rq_tready  (tready)
  );

  // Expected HDR beat: tag at [103:96], MemWr/dword-count word 0x0801 at [79:64], DW address below.
  function automatic logic [127:0] exp_hdr(input logic [63:0] addr, input logic [7:0] tag);
    return {24'h0, tag, 16'h0000, 16'h0801, addr[63:2], 2'b00};
  endfunction

  // Monitor on dut: handshaken beats, done pulses and stall-stability violations.
  int    cyc = 0;
  beat_t hs_q[$];
  int    hs_cyc_q[$];
  int    sq_done_cyc[$];
  int    cq_done_cyc[$];
  int    stall_viol = 0;
  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    beat_t cur;
    cur = {tdata_a, tkeep_a, tlast_a, tuser_a};
    if (!rst_n || !lnk_up) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tvalid_a || cur != prev_beat)) stall_viol++;
      prev_stall = tvalid_a && !tready;
      prev_beat  = cur;
      if (tvalid_a && tready) begin
        hs_q.push_back(cur);
        hs_cyc_q.push_back(cyc);
      end
    end
    if (sq_done_a) sq_done_cyc.push_back(cyc);
    if (cq_done_a) cq_done_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_q.delete();
    hs_cyc_q.delete();
    sq_done_cyc.delete();
    cq_done_cyc.delete();
  endtask

  task automatic wait_done(input int n, input bit rnd, input string name);
    int k;
    k = 0;
    while ((sq_done_cyc.size() + cq_done_cyc.size()) < n && k < 400) begin
      tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      tick();
      k++;
    end
    tests_run++;
    if (k >= 400) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d done pulses, need %0d", name,
               sq_done_cyc.size() + cq_done_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lnk_up = 1'b1; wsq = 1'b0; wcq = 1'b0;
    sqa = '0; cqa = '0; tready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({tvalid_a, tlast_a, sq_done_a, cq_done_a} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b exp 0000", {tvalid_a, tlast_a, sq_done_a, cq_done_a});
    end
    tests_run++;
    if ({tdata_a, tkeep_a, tuser_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h/%h exp 0", tdata_a, tkeep_a, tuser_a);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (tvalid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_tvalid: got %b exp 0", tvalid_a);
    end
    exp_tag = 8'd0;
  endtask

  task automatic test_single_sq();
    tready = 1'b1;
    wsq = 1'b1; sqa = 64'hFFFF_0000_1234_0005;
    tick(); wsq = 1'b0;                       // cycle N+1
    tests_run++;
    if (tvalid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sq_n1_tvalid: got %b exp 0", tvalid_a);
    end
    tick();                                   // N+2: HDR
    tests_run++;
    if (tvalid_a !== 1'b1 || tdata_a !== exp_hdr(BAR + 64'h1000, exp_tag)) begin
      tests_failed++;
      $display("FAIL sq_hdr: got v=%b %h exp v=1 %h", tvalid_a, tdata_a, exp_hdr(BAR + 64'h1000, exp_tag));
    end
    tests_run++;
    if ({tkeep_a, tlast_a, tuser_a} !== {4'hF, 1'b0, 62'hF}) begin
      tests_failed++;
      $display("FAIL sq_hdr_side: got keep=%h last=%b user=%h exp F/0/F", tkeep_a, tlast_a, tuser_a);
    end
    tick();                                   // N+3: DATA
    tests_run++;
    if (tvalid_a !== 1'b1 || tdata_a !== 128'h5 || {tkeep_a, tlast_a, tuser_a} !== {4'h1, 1'b1, 62'h0}) begin
      tests_failed++;
      $display("FAIL sq_data: got v=%b %h keep=%h last=%b user=%h exp 5/1/1/0",
               tvalid_a, tdata_a, tkeep_a, tlast_a, tuser_a);
    end
    tick();                                   // N+4: done
    tests_run++;
    if ({sq_done_a, cq_done_a, tvalid_a} !== 3'b100) begin
      tests_failed++;
      $display("FAIL sq_done_n4: got sq=%b cq=%b v=%b exp 1/0/0", sq_done_a, cq_done_a, tvalid_a);
    end
    tick();
    tests_run++;
    if (sq_done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL sq_done_width: got %b exp 0", sq_done_a);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_cq_stride();
    tready = 1'b1;
    wcq = 1'b1; cqa = 64'h3;
    tick(); wcq = 1'b0;
    tick();                                   // N+2: HDR
    tests_run++;
    if (tdata_b !== exp_hdr(BAR + 64'h1018, exp_tag)) begin
      tests_failed++;
      $display("FAIL cq_stride_hdr: got %h exp %h", tdata_b, exp_hdr(BAR + 64'h1018, exp_tag));
    end
    tests_run++;
    if (tdata_a !== exp_hdr(BAR + 64'h1004, exp_tag)) begin
      tests_failed++;
      $display("FAIL cq_q0_hdr: got %h exp %h", tdata_a, exp_hdr(BAR + 64'h1004, exp_tag));
    end
    tick();                                   // N+3: DATA
    tests_run++;
    if (tdata_b !== 128'h3 || tlast_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL cq_stride_data: got %h last=%b exp 3/1", tdata_b, tlast_b);
    end
    tick();                                   // N+4
    tests_run++;
    if ({cq_done_b, sq_done_b} !== 2'b10) begin
      tests_failed++;
      $display("FAIL cq_stride_done: got cq=%b sq=%b exp 1/0", cq_done_b, sq_done_b);
    end
    tick();
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_simultaneous();
    int n0;
    clear_mon();
    tready = 1'b1;
    wsq = 1'b1; sqa = 64'h2; wcq = 1'b1; cqa = 64'h7;
    n0 = cyc;
    tick(); wsq = 1'b0; wcq = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (cq_done_cyc.size() != 1 || cq_done_cyc[0] != n0 + 4) begin
      tests_failed++;
      $display("FAIL simul_cq_done: got %0d pulses first@+%0d exp 1@+4", cq_done_cyc.size(),
               cq_done_cyc.size() ? cq_done_cyc[0] - n0 : -1);
    end
    tests_run++;
    if (sq_done_cyc.size() != 1 || sq_done_cyc[0] != n0 + 8) begin
      tests_failed++;
      $display("FAIL simul_sq_done: got %0d pulses first@+%0d exp 1@+8", sq_done_cyc.size(),
               sq_done_cyc.size() ? sq_done_cyc[0] - n0 : -1);
    end
    tests_run++;
    if (hs_q.size() != 4) begin
      tests_failed++;
      $display("FAIL simul_beats: got %0d beats exp 4", hs_q.size());
    end else begin
      tests_run++;
      if (hs_q[0].data !== exp_hdr(BAR + 64'h1004, exp_tag) || hs_q[1].data !== 128'h7) begin
        tests_failed++;
        $display("FAIL simul_cq_tlp: got %h/%h exp %h/7", hs_q[0].data, hs_q[1].data,
                 exp_hdr(BAR + 64'h1004, exp_tag));
      end
      tests_run++;
      if (hs_q[2].data !== exp_hdr(BAR + 64'h1000, exp_tag + 8'd1) || hs_q[3].data !== 128'h2
          || hs_cyc_q[2] != n0 + 6) begin
        tests_failed++;
        $display("FAIL simul_sq_tlp: got %h/%h @+%0d exp %h/2 @+6", hs_q[2].data, hs_q[3].data,
                 hs_cyc_q[2] - n0, exp_hdr(BAR + 64'h1000, exp_tag + 8'd1));
      end
    end
    exp_tag = exp_tag + 8'd2;
  endtask

  task automatic test_coalesce();
    // Second pulse lands while the first is being frozen: two TLPs, 1 then 4.
    clear_mon();
    tready = 1'b0;
    wsq = 1'b1; sqa = 64'h1;
    tick(); sqa = 64'h4;
    tick(); wsq = 1'b0;
    repeat (2) tick();
    wait_done(2, 1'b0, "coal_a");
    repeat (3) tick();
    tests_run++;
    if (hs_q.size() != 4) begin
      tests_failed++;
      $display("FAIL coal_a_beats: got %0d exp 4", hs_q.size());
    end else begin
      tests_run++;
      if (hs_q[1].data !== 128'h1 || hs_q[3].data !== 128'h4
          || hs_q[2].data !== exp_hdr(BAR + 64'h1000, exp_tag + 8'd1)) begin
        tests_failed++;
        $display("FAIL coal_a_vals: got %h/%h hdr2=%h exp 1/4", hs_q[1].data, hs_q[3].data, hs_q[2].data);
      end
    end
    exp_tag = exp_tag + 8'd2;
    // Two pulses while the first TLP stalls in HDR coalesce into one TLP carrying 8.
    clear_mon();
    tready = 1'b0;
    wsq = 1'b1; sqa = 64'h1;
    tick(); wsq = 1'b0;
    repeat (2) tick();
    wsq = 1'b1; sqa = 64'h6;
    tick(); sqa = 64'h8;
    tick(); wsq = 1'b0;
    wait_done(2, 1'b0, "coal_b");
    repeat (8) tick();
    tests_run++;
    if (hs_q.size() != 4 || sq_done_cyc.size() != 2) begin
      tests_failed++;
      $display("FAIL coal_b_count: got %0d beats %0d dones exp 4/2", hs_q.size(), sq_done_cyc.size());
    end else begin
      tests_run++;
      if (hs_q[1].data !== 128'h1 || hs_q[3].data !== 128'h8) begin
        tests_failed++;
        $display("FAIL coal_b_vals: got %h/%h exp 1/8", hs_q[1].data, hs_q[3].data);
      end
    end
`ifdef NVME_DB_WRITER_STATS_EN
    tests_run++;
    if (coal_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL coal_count: got %0d exp 1", coal_a);
    end
`endif
    exp_tag = exp_tag + 8'd2;
  endtask

  task automatic test_link_drop();
    int n0;
    clear_mon();
    tready = 1'b0;
    wsq = 1'b1; sqa = 64'h9;
    tick(); wsq = 1'b0;
    tick();
    wcq = 1'b1; cqa = 64'h55;                 // pending CQ behind the stalled SQ TLP
    tick(); wcq = 1'b0;
    tests_run++;
    if (tvalid_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_pre_tvalid: got %b exp 1", tvalid_a);
    end
    lnk_up = 1'b0;
    tick();
    tests_run++;
    if (tvalid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_tvalid: got %b exp 0", tvalid_a);
    end
    wcq = 1'b1; cqa = 64'h66;                 // ignored while the link is down
    tick(); wcq = 1'b0;
    tick();
    lnk_up = 1'b1; tready = 1'b1;
    repeat (12) tick();
    tests_run++;
    if (hs_q.size() != 0 || sq_done_cyc.size() != 0 || cq_done_cyc.size() != 0) begin
      tests_failed++;
      $display("FAIL drop_quiet: got %0d beats %0d/%0d dones exp 0", hs_q.size(),
               sq_done_cyc.size(), cq_done_cyc.size());
    end
    clear_mon();
    wsq = 1'b1; sqa = 64'hA;
    n0 = cyc;
    tick(); wsq = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (sq_done_cyc.size() != 1 || sq_done_cyc[0] != n0 + 4 || hs_q.size() != 2) begin
      tests_failed++;
      $display("FAIL drop_recover_done: got %0d dones first@+%0d %0d beats exp 1@+4/2",
               sq_done_cyc.size(), sq_done_cyc.size() ? sq_done_cyc[0] - n0 : -1, hs_q.size());
    end else begin
      tests_run++;
      if (hs_q[0].data !== exp_hdr(BAR + 64'h1000, exp_tag) || hs_q[1].data !== 128'hA) begin
        tests_failed++;
        $display("FAIL drop_recover_tlp: got %h/%h exp %h/A", hs_q[0].data, hs_q[1].data,
                 exp_hdr(BAR + 64'h1000, exp_tag));
      end
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_backpressure();
    localparam int N = 260;
    logic [15:0] vals [N];
    bit          is_cq [N];
    int          n_sq, n_cq, si, ci, dcyc, errs;
    logic [63:0] addr;
    clear_mon();
    n_sq = 0; n_cq = 0;
    for (int i = 0; i < N; i++) begin
      vals[i]  = 16'(i * 37 + 3);
      is_cq[i] = (i % 3 == 0);
      if (is_cq[i]) begin
        wcq = 1'b1; cqa = {48'hDEAD_BEEF_CAFE, vals[i]}; n_cq++;
      end else begin
        wsq = 1'b1; sqa = {48'hDEAD_BEEF_CAFE, vals[i]}; n_sq++;
      end
      tready = ($urandom_range(0, 9) < 3);
      tick(); wsq = 1'b0; wcq = 1'b0;
      wait_done(i + 1, 1'b1, "bp");
    end
    tready = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (stall_viol != 0) begin
      tests_failed++;
      $display("FAIL bp_stall_stable: got %0d violations exp 0", stall_viol);
    end
    tests_run++;
    if (hs_q.size() != 2 * N || sq_done_cyc.size() != n_sq || cq_done_cyc.size() != n_cq) begin
      tests_failed++;
      $display("FAIL bp_counts: got %0d beats %0d/%0d dones exp %0d %0d/%0d", hs_q.size(),
               sq_done_cyc.size(), cq_done_cyc.size(), 2 * N, n_sq, n_cq);
    end else begin
      si = 0; ci = 0;
      for (int i = 0; i < N; i++) begin
        addr = is_cq[i] ? BAR + 64'h1004 : BAR + 64'h1000;
        errs = 0;
        tests_run++;
        if (hs_q[2*i].data !== exp_hdr(addr, exp_tag + 8'(i))
            || {hs_q[2*i].keep, hs_q[2*i].last, hs_q[2*i].user} !== {4'hF, 1'b0, 62'hF}) begin
          tests_failed++; errs++;
          $display("FAIL bp_hdr_%0d: got %h exp %h", i, hs_q[2*i].data, exp_hdr(addr, exp_tag + 8'(i)));
        end
        tests_run++;
        if (hs_q[2*i+1].data !== 128'(vals[i])
            || {hs_q[2*i+1].keep, hs_q[2*i+1].last, hs_q[2*i+1].user} !== {4'h1, 1'b1, 62'h0}) begin
          tests_failed++; errs++;
          $display("FAIL bp_data_%0d: got %h exp %h", i, hs_q[2*i+1].data, vals[i]);
        end
        dcyc = is_cq[i] ? cq_done_cyc[ci] : sq_done_cyc[si];
        if (is_cq[i]) ci++; else si++;
        tests_run++;
        if (dcyc != hs_cyc_q[2*i+1] + 1) begin
          tests_failed++;
          $display("FAIL bp_done_lat_%0d: got done@%0d exp %0d", i, dcyc, hs_cyc_q[2*i+1] + 1);
        end
      end
    end
    exp_tag = exp_tag + 8'(N);
  endtask

  task automatic test_async_reset();
    clear_mon();
    tready = 1'b0;
    wsq = 1'b1; sqa = 64'hB;
    tick(); wsq = 1'b0;
    repeat (2) tick();                        // HDR stalled
    #2 rst_n = 1'b0;                          // mid-cycle, away from the edge
    #1;
    tests_run++;
    if (tvalid_a !== 1'b0 || tdata_a !== '0) begin
      tests_failed++;
      $display("FAIL areset_abort: got v=%b %h exp 0", tvalid_a, tdata_a);
    end
    repeat (2) tick();
    rst_n = 1'b1; tready = 1'b1;
    repeat (2) tick();
    clear_mon();
    wsq = 1'b1; sqa = 64'hC;
    tick(); wsq = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (hs_q.size() != 2 || hs_q[0].data !== exp_hdr(BAR + 64'h1000, 8'd0) || hs_q[1].data !== 128'hC) begin
      tests_failed++;
      $display("FAIL areset_tag0: got %0d beats hdr=%h exp 2 beats %h", hs_q.size(),
               hs_q.size() ? hs_q[0].data : 128'h0, exp_hdr(BAR + 64'h1000, 8'd0));
    end
  endtask

  initial begin
    test_reset();
    test_single_sq();
    test_cq_stride();
    test_simultaneous();
    test_coalesce();
    test_link_drop();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
